piso_serializer: RTL and testbench

Parallel-in/serial-out serializer that feeds the 4-bit serial shift register chain: it accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on `sout`, which drives the downstream serial input. It sits directly upstream of the shift register, and its `sout_valid` strobe qualifies each bit. Words can be issued back-to-back with no idle cycle, so the downstream chain sees a continuous bit stream.

---
 rtl/piso_pkg.sv | 16 +
 rtl/piso_bit_counter.sv | 28 ++
 rtl/piso_serializer.sv | 118 +++++++++++
 tb/tb_piso_serializer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// Optional parity framing is selected with the PISO_PARITY_EN macro.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  // Bit counter width able to hold 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter for the serializer; flags when the count reaches zero.
// Saturates at zero so it can never wrap.
module piso_bit_counter #(
  parameter int CW       = 3,
  parameter int LOAD_VAL = 3
) (
  input  logic clock,
  input  logic clear,
  input  logic load,
  input  logic dec,
  output logic last
);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(LOAD_VAL);
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with gapless back-to-back framing.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  // Handshake: a word transfers on a rising edge where din_valid && din_ready.
  // din_ready depends only on registered state (and clear), never on din_valid.

  piso_state_t      state;
  piso_state_t      state_next;
  logic [WIDTH-1:0] shreg;
  logic             xfer;
  logic             frame_end;
  logic             cnt_last;
  logic             cnt_dec;
`ifdef PISO_PARITY_EN
  logic             par_bit;
`endif

  piso_bit_counter #(
    .CW       (CW),
    .LOAD_VAL (WIDTH - 1)
  ) u_bit_counter (
    .clock (clock),
    .clear (clear),
    .load  (xfer),
    .dec   (cnt_dec),
    .last  (cnt_last)
  );

  // frame_end marks the cycle that closes a frame and may accept the next word.
  always_comb begin
`ifdef PISO_PARITY_EN
    frame_end = (state == PARITY);
`else
    frame_end = (state == SHIFT) && cnt_last;
`endif
    din_ready  = !clear && ((state == IDLE) || frame_end);
    xfer       = din_valid && din_ready;
    cnt_dec    = (state == SHIFT) && !cnt_last;
    done       = frame_end;
    busy       = (state != IDLE);
    sout_valid = (state != IDLE);
  end

  always_comb begin
    sout       = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (xfer) state_next = SHIFT;
      end
      SHIFT: begin
        sout = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
        if (cnt_last) begin
`ifdef PISO_PARITY_EN
          state_next = PARITY;
`else
          state_next = xfer ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        sout       = par_bit;
        state_next = xfer ? SHIFT : IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      shreg <= '0;
    end else if (xfer) begin
      shreg <= din;
    end else if (state == SHIFT) begin
      shreg <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
    end
  end

`ifdef PISO_PARITY_EN
  // Parity is taken from the captured word, so later din changes cannot affect it.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      par_bit <= 1'b0;
    end else if (xfer) begin
      par_bit <= ^din;
    end
  end
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances plus a
// model of the downstream 4-bit shift register chain. Honours PISO_PARITY_EN.
module tb_piso_serializer;

  logic       clock = 1'b0;
  logic       clear;

  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sout;
  logic       sout_valid;
  logic       busy;
  logic       done;

  logic [3:0] din_l;
  logic       din_valid_l;
  logic       din_ready_l;
  logic       sout_l;
  logic       sout_valid_l;
  logic       busy_l;
  logic       done_l;

  logic       e, d, c, b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
    .clock      (clock),
    .clear      (clear),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
    .clock      (clock),
    .clear      (clear),
    .din        (din_l),
    .din_valid  (din_valid_l),
    .din_ready  (din_ready_l),
    .sout       (sout_l),
    .sout_valid (sout_valid_l),
    .busy       (busy_l),
    .done       (done_l)
  );

  // Downstream serial chain fed by the MSB-first instance.
  always @(posedge clock or posedge clear) begin
    if (clear) begin
      {e, d, c, b} <= 4'b0000;
    end else if (sout_valid) begin
      {e, d, c, b} <= {d, c, b, sout};
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic s, input logic dn, input logic rdy);
    chk({tag, "_sout"}, {7'b0, sout}, {7'b0, s});
    chk({tag, "_valid"}, {7'b0, sout_valid}, 8'd1);
    chk({tag, "_busy"}, {7'b0, busy}, 8'd1);
    chk({tag, "_done"}, {7'b0, done}, {7'b0, dn});
    chk({tag, "_ready"}, {7'b0, din_ready}, {7'b0, rdy});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sout"}, {7'b0, sout}, 8'd0);
    chk({tag, "_valid"}, {7'b0, sout_valid}, 8'd0);
    chk({tag, "_busy"}, {7'b0, busy}, 8'd0);
    chk({tag, "_done"}, {7'b0, done}, 8'd0);
  endtask

  initial begin
    logic [7:0] seq;

    clear       = 1'b1;
    din         = 4'h0;
    din_valid   = 1'b0;
    din_l       = 4'h0;
    din_valid_l = 1'b0;

    // Reset values while clear is high.
    #12;
    chk_idle("rst");
    chk("rst_ready", {7'b0, din_ready}, 8'd0);
    chk("rst_ready_l", {7'b0, din_ready_l}, 8'd0);
    chk("rst_valid_l", {7'b0, sout_valid_l}, 8'd0);
    #1;
    clear = 1'b0;
    #1;
    chk("idle_ready", {7'b0, din_ready}, 8'd1);

`ifdef PISO_PARITY_EN
    // Parity frame: 0111 -> 0,1,1,1 then parity 1.
    din = 4'b0111; din_valid = 1'b1;
    step;
    din_valid = 1'b0;
    seq = 8'b0000_1111;
    for (int k = 0; k < 5; k++) begin
      chk_bit($sformatf("par%0d", k), seq[4-k], (k == 4), (k == 4));
      step;
    end
    chk_idle("par_end");
`else
    // Basic MSB-first frame 1011.
    din = 4'b1011; din_valid = 1'b1;
    step;
    din_valid = 1'b0;
    seq = 8'b0000_1011;
    for (int k = 0; k < 4; k++) begin
      chk_bit($sformatf("msb%0d", k), seq[3-k], (k == 3), (k == 3));
      step;
    end
    chk_idle("msb_end");
    chk("chain_edcb", {4'b0, e, d, c, b}, 8'b0000_1011);

    // LSB-first frame 0001 -> 1,0,0,0.
    din_l = 4'b0001; din_valid_l = 1'b1;
    step;
    din_valid_l = 1'b0;
    seq = 8'b0000_1000;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lsb%0d_sout", k), {7'b0, sout_l}, {7'b0, seq[3-k]});
      chk($sformatf("lsb%0d_done", k), {7'b0, done_l}, {7'b0, (k == 3)});
      step;
    end
    chk("lsb_end_valid", {7'b0, sout_valid_l}, 8'd0);

    // Back-to-back A then 5, second accepted on the last-bit cycle.
    din = 4'hA; din_valid = 1'b1;
    step;
    din = 4'h5;
    seq = 8'b1010_0101;
    for (int k = 0; k < 8; k++) begin
      chk_bit($sformatf("b2b%0d", k), seq[7-k], (k == 3 || k == 7), (k == 3 || k == 7));
      step;
      if (k == 3) din_valid = 1'b0;
    end
    chk_idle("b2b_end");

    // Stall: din_valid held high with din changing mid-frame.
    din = 4'b0110; din_valid = 1'b1;
    step;
    seq = 8'b0000_0110;
    for (int k = 0; k < 4; k++) begin
      chk_bit($sformatf("stall%0d", k), seq[3-k], (k == 3), (k == 3));
      din = (k < 3) ? 4'($urandom_range(0, 15)) : 4'hF;
      step;
    end
    din_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_bit($sformatf("stallf%0d", k), 1'b1, (k == 3), (k == 3));
      step;
    end
    chk_idle("stall_end");

    // Reset mid-frame on bit 2, then a fresh frame 1100.
    din = 4'b0101; din_valid = 1'b1;
    step;
    din_valid = 1'b0;
    chk_bit("mid_b1", 1'b0, 1'b0, 1'b0);
    step;
    clear = 1'b1;
    #1;
    chk_idle("mid_clr");
    chk("mid_clr_ready", {7'b0, din_ready}, 8'd0);
    #2;
    clear = 1'b0;
    #1;
    chk("mid_ready", {7'b0, din_ready}, 8'd1);
    din = 4'b1100; din_valid = 1'b1;
    step;
    din_valid = 1'b0;
    seq = 8'b0000_1100;
    for (int k = 0; k < 4; k++) begin
      chk_bit($sformatf("post%0d", k), seq[3-k], (k == 3), (k == 3));
      step;
    end
    chk_idle("post_end");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
